// File: rtl/memory_16x32_pkg.sv
// Shared sizes and types for the 16x32 scratch memory.
package memory_16x32_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 4;
   localparam int unsigned MEMO_DEPTH = 1 << ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : memory_16x32_pkg

// File: rtl/memory_16x32_array.sv
// Flop-based register array: one write port, one asynchronous read port,
// and a synchronous clear that zeroes every word in a single edge.
module memory_16x32_array
   import memory_16x32_pkg::*;
(
   input  logic  clk_i,
   input  logic  clr_i,
   input  logic  we_i,
   input  addr_t waddr_i,
   input  word_t wdata_i,
   input  addr_t raddr_i,
   output word_t rdata_o
);

   word_t mem_q [MEMO_DEPTH];

   // Clear outranks the write port.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < int'(MEMO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : memory_16x32_array

// File: rtl/memory_16x32.sv
// Single-port 16x32 scratch memory: EN high writes, EN low reads into a
// registered Data_out qualified by Valid_out.
module memory_16x32
   import memory_16x32_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  word_t Data_in,
   input  addr_t Address,
   input  logic  EN,
   output word_t Data_out,
   output logic  Valid_out
);

   word_t rdata;
   word_t data_q, data_d;
   logic  valid_q, valid_d;

   memory_16x32_array u_array (
      .clk_i   (CLK),
      .clr_i   (RST),
      .we_i    (EN),
      .waddr_i (Address),
      .wdata_i (Data_in),
      .raddr_i (Address),
      .rdata_o (rdata)
   );

   // Writes hold the last read result and drop valid; reads capture the array.
   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (!EN) begin
         data_d  = rdata;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign Data_out  = data_q;
   assign Valid_out = valid_q;

endmodule : memory_16x32

// File: tb/tb_memory_16x32.sv
// Directed bench for memory_16x32: the driver queues the expected output of
// each cycle, a monitor on the falling edge pops and compares.
module tb_memory_16x32;
   import memory_16x32_pkg::*;

   logic  CLK = 1'b0;
   logic  RST = 1'b0;
   logic  EN  = 1'b0;
   addr_t Address = '0;
   word_t Data_in = '0;
   word_t Data_out;
   logic  Valid_out;

   memory_16x32 dut (
      .CLK       (CLK),
      .RST       (RST),
      .Data_in   (Data_in),
      .Address   (Address),
      .EN        (EN),
      .Data_out  (Data_out),
      .Valid_out (Valid_out)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string name;
      word_t d;
      logic  v;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   word_t       last_rd = '0;

   // One clock of stimulus; optionally queue the output expected after the edge.
   task automatic cyc(input logic rst, input logic en, input addr_t a,
                      input word_t din, input logic chk, input string nm,
                      input word_t ed, input logic ev);
      RST = rst; EN = en; Address = a; Data_in = din;
      @(posedge CLK);
      if (chk) sb_q.push_back('{nm, ed, ev});
      #1;
   endtask

   task automatic wr(input addr_t a, input word_t d, input string nm);
      cyc(1'b0, 1'b1, a, d, 1'b1, nm, last_rd, 1'b0);
   endtask

   task automatic rd(input addr_t a, input word_t e, input string nm);
      cyc(1'b0, 1'b0, a, 32'h0BAD_0BAD, 1'b1, nm, e, 1'b1);
      last_rd = e;
   endtask

   task automatic rst_cyc(input logic en, input addr_t a, input word_t d, input string nm);
      cyc(1'b1, en, a, d, 1'b1, nm, '0, 1'b0);
      last_rd = '0;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         n_vec++;
         if (Data_out !== e.d || Valid_out !== e.v) begin
            n_miss++;
            $display("FAIL %s: got Data_out=%h Valid_out=%b, expected %h/%b",
                     e.name, Data_out, Valid_out, e.d, e.v);
         end
      end
   end

   initial begin
      // Junk in the array before the first reset; outputs not checked yet.
      for (int i = 0; i < 16; i++)
         cyc(1'b0, 1'b1, addr_t'(i), 32'h5555_0000 + 32'(i), 1'b0, "", '0, 1'b0);

      rst_cyc(1'b0, '0, '0, "reset_outputs");
      for (int i = 0; i < 16; i++) rd(addr_t'(i), 32'h0, "reset_clears_array");

      for (int i = 0; i < 16; i++) begin
         wr(addr_t'(i), 32'hA5A5_0000 + 32'(i), "write_valid_low");
         rd(addr_t'(i), 32'hA5A5_0000 + 32'(i), "read_after_write");
      end

      wr(4'd3, 32'hDEAD_BEEF, "overwrite_first");
      wr(4'd3, 32'h1234_5678, "overwrite_second");
      rd(4'd3, 32'h1234_5678, "overwrite_read3");
      rd(4'd4, 32'hA5A5_0004, "overwrite_addr4_kept");

      wr(4'd5, 32'hCAFE_F00D, "hold_setup");
      rd(4'd5, 32'hCAFE_F00D, "hold_read5");
      for (int k = 0; k < 3; k++) wr(4'd6, 32'h6666_0000 + 32'(k), "hold_during_write");
      rd(4'd6, 32'h6666_0002, "hold_last_write6");

      for (int i = 0; i < 16; i++) wr(addr_t'(i), 32'hFFFF_FFFF, "fill_ones");
      rd(4'd9, 32'hFFFF_FFFF, "fill_read9");
      cyc(1'b1, 1'b0, 4'd10, '0, 1'b1, "reset_during_read", '0, 1'b0);
      last_rd = '0;
      for (int i = 0; i < 16; i++) rd(addr_t'(i), 32'h0, "after_mid_reset");

      wr(4'd7, 32'h7777_7777, "prio_setup");
      rst_cyc(1'b1, 4'd7, 32'h1, "reset_over_write");
      rd(4'd7, 32'h0, "prio_write_suppressed");
      rd(4'd7, 32'h0, "back_to_back_read");

      EN = 1'b1; Address = '0; Data_in = '0;
      for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(posedge CLK);
      @(posedge CLK);
      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_memory_16x32
